// File: rtl/comparador_blink_n.sv
// Debounced unsigned W-bit comparator with registered flags and a status LED.
// The LED is steady on equality, blinks fast when a > b and slow when a < b.
module comparador_blink_n #(
    parameter int W              = 3,
    parameter int ACTIVE_LOW     = 0,
    parameter int ACTIVE_LOW_LED = 0,
    parameter int F_CLK_HZ       = 25_000_000,
    parameter int DEB_MS         = 5,
    parameter int FAST_MS        = 125,
    parameter int SLOW_MS        = 500
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [5:0]   y,
    output logic         y_chg,
    output logic         led
);

    localparam int CYC  = F_CLK_HZ / 1000;
    localparam int PW   = (CYC > 1) ? $clog2(CYC) : 1;
    localparam int MAXH = (FAST_MS > SLOW_MS) ? FAST_MS : SLOW_MS;
    localparam int HW   = $clog2(MAXH + 1);

    typedef enum logic [1:0] {
        ST_STEADY,
        ST_FAST,
        ST_SLOW
    } state_t;

    logic [2*W-1:0] raw;
    logic [2*W-1:0] s1;
    logic [2*W-1:0] s2;
    logic [2*W-1:0] acc;
    logic [W-1:0]   acc_a;
    logic [W-1:0]   acc_b;
    logic [PW-1:0]  pre;
    logic           tick;
    logic [5:0]     y_nx;
    state_t         state;
    state_t         st_nx;
    logic [HW-1:0]  phase;
    logic [HW-1:0]  half;
    logic           led_raw;

    assign raw = (ACTIVE_LOW != 0) ? ~{in_a, in_b} : {in_a, in_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    assign tick = (pre == PW'(CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    generate
        if (DEB_MS == 0) begin : g_nodeb
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc <= '0;
                end else begin
                    acc <= s2;
                end
            end
        end else begin : g_deb
            localparam int DW = $clog2(DEB_MS + 1);

            logic [2*W-1:0] cand;
            logic [DW-1:0]  stab;

            // stab saturates at DEB_MS so a held vector is accepted once
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cand <= '0;
                    stab <= '0;
                    acc  <= '0;
                end else if (s2 != cand) begin
                    cand <= s2;
                    stab <= '0;
                end else if (tick && (stab != DW'(DEB_MS))) begin
                    stab <= stab + DW'(1);
                    if (stab == DW'(DEB_MS - 1)) begin
                        acc <= cand;
                    end
                end
            end
        end
    endgenerate

    assign acc_a = acc[2*W-1:W];
    assign acc_b = acc[W-1:0];

    always_comb begin
        y_nx = {
            acc_a <= acc_b,
            acc_a >= acc_b,
            acc_a <  acc_b,
            acc_a >  acc_b,
            acc_a != acc_b,
            acc_a == acc_b
        };
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= 6'b110001;
            y_chg <= 1'b0;
        end else begin
            y     <= y_nx;
            y_chg <= (y_nx != y);
        end
    end

    always_comb begin
        st_nx = ST_STEADY;
        unique case (1'b1)
            y[0]:    st_nx = ST_STEADY;
            y[2]:    st_nx = ST_FAST;
            y[3]:    st_nx = ST_SLOW;
            default: st_nx = ST_STEADY;
        endcase
    end

    assign half = (state == ST_FAST) ? HW'(FAST_MS) : HW'(SLOW_MS);

    // a new state always opens with a fresh on phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_STEADY;
            phase   <= '0;
            led_raw <= 1'b0;
        end else if (st_nx != state) begin
            state   <= st_nx;
            phase   <= '0;
            led_raw <= 1'b1;
        end else if (state == ST_STEADY) begin
            phase   <= '0;
            led_raw <= 1'b1;
        end else if (tick) begin
            if (phase == half - HW'(1)) begin
                phase   <= '0;
                led_raw <= ~led_raw;
            end else begin
                phase <= phase + HW'(1);
            end
        end
    end

    assign led = led_raw ^ (ACTIVE_LOW_LED != 0);

endmodule
